pic_ack_ctrl: RTL and testbench

- Interrupt acknowledge and in-service stage directly downstream of the priority resolver in the 8259-style PIC.
- Takes the resolver's winning request and raises INT to the CPU.
- Runs the two-pulse INTA sequence: sets the ISR bit, clears the IRR bit, then drives the vector byte.
- Retires ISR bits on EOI commands or automatic EOI, and maintains the rotating lowest-priority pointer that the resolver consumes.

---
 rtl/pic_ack_ctrl.sv | 175 +++++++++++++++++
 tb/tb_pic_ack_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/pic_ack_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pic_ack_ctrl
// Purpose  : 8259-style INT/INTA sequencer, in-service register, EOI and
//            rotating lowest-priority pointer.
// Revision : 1.0 - initial release
// ============================================================================
module pic_ack_ctrl #(
  parameter int NUM_IRQ = 8,
  parameter int ID_W    = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               int_req,
  input  logic [ID_W-1:0]    int_id,
  input  logic               inta_n,
  input  logic               aeoi,
  input  logic               rot,
  input  logic               eoi_cmd,
  input  logic               eoi_specific,
  input  logic [ID_W-1:0]    eoi_level,
  input  logic [4:0]         vec_base,
  output logic               int_out,
  output logic [NUM_IRQ-1:0] isr,
  output logic [NUM_IRQ-1:0] irr_clr,
  output logic [ID_W-1:0]    prio_low,
  output logic [7:0]         data_out,
  output logic               data_oe
);

  localparam logic [2:0] c_st_idle = 3'd0;
  localparam logic [2:0] c_st_req  = 3'd1;
  localparam logic [2:0] c_st_ack1 = 3'd2;
  localparam logic [2:0] c_st_gap  = 3'd3;
  localparam logic [2:0] c_st_ack2 = 3'd4;

  logic [2:0]         r_state;
  logic [2:0]         w_state_nxt;
  logic               r_inta_n_q;
  logic               w_fall;
  logic               w_rise;
  logic [ID_W-1:0]    r_lvl;
  logic               r_spur;
  logic               r_int_out;
  logic [NUM_IRQ-1:0] r_isr;
  logic [NUM_IRQ-1:0] r_irr_clr;
  logic [ID_W-1:0]    r_prio_low;
  logic [7:0]         r_data_out;
  logic               r_data_oe;

  logic               w_req;
  logic               w_ack1;
  logic               w_vec;
  logic               w_done;
  logic [NUM_IRQ-1:0] w_set;
  logic [NUM_IRQ-1:0] w_aeoi_clr;
  logic               w_aeoi_prio;
  logic [NUM_IRQ-1:0] w_eoi_clr;
  logic               w_eoi_prio_vld;
  logic [ID_W-1:0]    w_eoi_prio;
  logic               w_ns_found;
  logic [ID_W-1:0]    w_ns_lvl;

  assign w_fall = r_inta_n_q & ~inta_n;
  assign w_rise = ~r_inta_n_q & inta_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= c_st_idle;
      r_inta_n_q <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_inta_n_q <= inta_n;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle: if (int_req) w_state_nxt = c_st_req;
      c_st_req:  if (w_fall)  w_state_nxt = c_st_ack1;
      c_st_ack1: if (w_rise)  w_state_nxt = c_st_gap;
      c_st_gap:  if (w_fall)  w_state_nxt = c_st_ack2;
      c_st_ack2: if (w_rise)  w_state_nxt = c_st_idle;
      default:                w_state_nxt = c_st_idle;
    endcase
  end

  // Sequence strobes; the datapath below acts on them at the same edge.
  always_comb begin
    w_req  = (r_state == c_st_idle) & int_req;
    w_ack1 = (r_state == c_st_req)  & w_fall;
    w_vec  = (r_state == c_st_gap)  & w_fall;
    w_done = (r_state == c_st_ack2) & w_rise;
  end

  // Scan from lowest to highest priority so the highest-priority set bit wins.
  always_comb begin
    w_ns_found = 1'b0;
    w_ns_lvl   = '0;
    for (int k = NUM_IRQ; k >= 1; k--) begin
      if (r_isr[r_prio_low + ID_W'(k)]) begin
        w_ns_found = 1'b1;
        w_ns_lvl   = r_prio_low + ID_W'(k);
      end
    end
  end

  always_comb begin
    w_eoi_clr      = '0;
    w_eoi_prio_vld = 1'b0;
    w_eoi_prio     = '0;
    if (eoi_cmd) begin
      if (eoi_specific) begin
        w_eoi_clr      = NUM_IRQ'(1) << eoi_level;
        w_eoi_prio_vld = rot;
        w_eoi_prio     = eoi_level;
      end else if (w_ns_found) begin
        w_eoi_clr      = NUM_IRQ'(1) << w_ns_lvl;
        w_eoi_prio_vld = rot;
        w_eoi_prio     = w_ns_lvl;
      end
    end
  end

  assign w_set       = (w_ack1 & int_req) ? (NUM_IRQ'(1) << int_id) : '0;
  assign w_aeoi_clr  = (w_done & aeoi & ~r_spur) ? (NUM_IRQ'(1) << r_lvl) : '0;
  assign w_aeoi_prio = w_done & aeoi & ~r_spur & rot;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lvl      <= '1;
      r_spur     <= 1'b0;
      r_int_out  <= 1'b0;
      r_isr      <= '0;
      r_irr_clr  <= '0;
      r_prio_low <= '1;
      r_data_out <= '0;
      r_data_oe  <= 1'b0;
    end else begin
      if (w_ack1) begin
        r_lvl  <= int_req ? int_id : '1;
        r_spur <= ~int_req;
      end
      if (w_req) begin
        r_int_out <= 1'b1;
      end else if (w_ack1) begin
        r_int_out <= 1'b0;
      end
      r_isr     <= (r_isr & ~w_eoi_clr & ~w_aeoi_clr) | w_set;
      r_irr_clr <= w_set;
      if (w_eoi_prio_vld) begin
        r_prio_low <= w_eoi_prio;
      end else if (w_aeoi_prio) begin
        r_prio_low <= r_lvl;
      end
      if (w_vec) begin
        r_data_out <= {vec_base, r_lvl};
        r_data_oe  <= 1'b1;
      end else if (w_done) begin
        r_data_out <= '0;
        r_data_oe  <= 1'b0;
      end
    end
  end

  assign int_out  = r_int_out;
  assign isr      = r_isr;
  assign irr_clr  = r_irr_clr;
  assign prio_low = r_prio_low;
  assign data_out = r_data_out;
  assign data_oe  = r_data_oe;

endmodule
`default_nettype wire

// File: tb/tb_pic_ack_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pic_ack_ctrl
// Purpose  : Scoreboard bench for pic_ack_ctrl with a rank-based priority model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pic_ack_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       int_req;
  logic [2:0] int_id;
  logic       inta_n;
  logic       aeoi;
  logic       rot;
  logic       eoi_cmd;
  logic       eoi_specific;
  logic [2:0] eoi_level;
  logic [4:0] vec_base;
  logic       int_out;
  logic [7:0] isr;
  logic [7:0] irr_clr;
  logic [2:0] prio_low;
  logic [7:0] data_out;
  logic       data_oe;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] m_isr;
  int         m_prio;
  logic [7:0] q_irr[$];
  logic [7:0] q_vec[$];
  logic       prev_oe = 1'b0;

  always #5 clk = ~clk;

  pic_ack_ctrl #(.NUM_IRQ(8), .ID_W(3)) dut (
    .clk(clk), .rst(rst), .int_req(int_req), .int_id(int_id), .inta_n(inta_n),
    .aeoi(aeoi), .rot(rot), .eoi_cmd(eoi_cmd), .eoi_specific(eoi_specific),
    .eoi_level(eoi_level), .vec_base(vec_base), .int_out(int_out), .isr(isr),
    .irr_clr(irr_clr), .prio_low(prio_low), .data_out(data_out), .data_oe(data_oe)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference EOI: highest priority is the level just above prio_low.
  task automatic model_eoi(input bit spec, input int lvl, input bit r);
    if (spec) begin
      m_isr[lvl] = 1'b0;
      if (r) m_prio = lvl;
    end else begin
      for (int k = 1; k <= 8; k++) begin
        int l;
        l = (m_prio + k) % 8;
        if (m_isr[l]) begin
          m_isr[l] = 1'b0;
          if (r) m_prio = l;
          break;
        end
      end
    end
  endtask

  task automatic eoi(input bit spec, input int lvl, input bit r);
    eoi_cmd = 1'b1; eoi_specific = spec; eoi_level = 3'(lvl); rot = r;
    model_eoi(spec, lvl, r);
    step();
    eoi_cmd = 1'b0;
    chk("eoi_isr", isr, m_isr);
    chk("eoi_prio", prio_low, m_prio);
  endtask

  task automatic ack(input int lvl, input bit spur, input bit a, input bit r,
                     input logic [4:0] vb, input bit collide);
    int lv;
    lv = spur ? 7 : lvl;
    vec_base = vb; aeoi = a; rot = r;
    int_req = 1'b1; int_id = 3'(lvl);
    step();
    chk("int_raise", int_out, 1);
    if (spur) begin
      int_req = 1'b0;
      step();
      chk("int_hold", int_out, 1);
    end
    inta_n = 1'b0;
    if (!spur) q_irr.push_back(8'(1 << lvl));
    if (collide) begin
      eoi_cmd = 1'b1; eoi_specific = 1'b1; eoi_level = 3'(lvl);
      model_eoi(1'b1, lvl, r);
    end
    step();
    eoi_cmd = 1'b0; int_req = 1'b0;
    if (!spur) m_isr[lvl] = 1'b1;
    chk("ack1_int_low", int_out, 0);
    chk("ack1_isr", isr, m_isr);
    if (spur) chk("spur_irr", irr_clr, 0);
    repeat ($urandom_range(0, 2)) step();
    inta_n = 1'b1;
    step();
    repeat ($urandom_range(0, 2)) step();
    inta_n = 1'b0;
    q_vec.push_back({vb, 3'(lv)});
    step();
    chk("ack2_oe", data_oe, 1);
    repeat ($urandom_range(0, 2)) step();
    inta_n = 1'b1;
    step();
    if (a && !spur) begin
      m_isr[lvl] = 1'b0;
      if (r) m_prio = lvl;
    end
    chk("end_oe", data_oe, 0);
    chk("end_data", data_out, 0);
    chk("end_isr", isr, m_isr);
    chk("end_prio", prio_low, m_prio);
  endtask

  // Monitor: every irr_clr pulse and every vector drive must match a queued expectation.
  always @(negedge clk) begin
    if (irr_clr != 8'h00) begin
      if (q_irr.size() == 0) chk("irr_unexpected", irr_clr, 0);
      else chk("irr_pulse", irr_clr, q_irr.pop_front());
    end
    if (data_oe && !prev_oe) begin
      if (q_vec.size() == 0) chk("vec_unexpected", data_oe, 0);
      else chk("vector", data_out, q_vec.pop_front());
    end
    prev_oe = data_oe;
  end

  initial begin
    rst = 1'b1; int_req = 1'b0; int_id = 3'd0; inta_n = 1'b1; aeoi = 1'b0;
    rot = 1'b0; eoi_cmd = 1'b0; eoi_specific = 1'b0; eoi_level = 3'd0; vec_base = 5'h01;
    m_isr = 8'h00; m_prio = 7;
    step(); step();
    chk("rst_int", int_out, 0);
    chk("rst_isr", isr, 0);
    chk("rst_irr", irr_clr, 0);
    chk("rst_prio", prio_low, 7);
    chk("rst_data", data_out, 0);
    chk("rst_oe", data_oe, 0);
    rst = 1'b0;
    step();

    ack(3, 0, 0, 0, 5'h01, 0);
    chk("basic_isr", isr, 8'h08);
    ack(5, 0, 0, 0, 5'h01, 0);
    eoi(0, 0, 1);
    chk("ns_eoi1_isr", isr, 8'h20);
    chk("ns_eoi1_prio", prio_low, 3);
    eoi(0, 0, 1);
    chk("ns_eoi2_isr", isr, 8'h00);
    chk("ns_eoi2_prio", prio_low, 5);

    ack(6, 0, 1, 1, 5'h01, 0);
    chk("aeoi_isr", isr, 8'h00);
    chk("aeoi_prio", prio_low, 6);

    ack(2, 1, 0, 0, 5'h01, 0);
    chk("spur_isr", isr, 8'h00);

    ack(2, 0, 0, 0, 5'h01, 1);
    chk("collide_isr", isr, 8'h04);
    eoi(1, 2, 0);

    for (int i = 0; i < 40; i++) begin
      ack($urandom_range(0, 7), ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), 5'($urandom), 0);
      if ($urandom_range(0, 1) == 1)
        eoi(1'($urandom_range(0, 1)), $urandom_range(0, 7), 1'($urandom_range(0, 1)));
    end

    // Abort an acknowledge in the gap between INTA pulses.
    int_req = 1'b1; int_id = 3'd4; aeoi = 1'b0; rot = 1'b0;
    step();
    inta_n = 1'b0; q_irr.push_back(8'h10);
    step();
    int_req = 1'b0; inta_n = 1'b1;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_isr = 8'h00; m_prio = 7;
    chk("midrst_int", int_out, 0);
    chk("midrst_isr", isr, 0);
    chk("midrst_irr", irr_clr, 0);
    chk("midrst_prio", prio_low, 7);
    chk("midrst_data", data_out, 0);
    chk("midrst_oe", data_oe, 0);
    inta_n = 1'b0;
    step();
    repeat (4) step();
    chk("midrst_no_oe", data_oe, 0);
    chk("midrst_no_int", int_out, 0);
    inta_n = 1'b1;
    step(); step();

    chk("irr_q_empty", q_irr.size(), 0);
    chk("vec_q_empty", q_vec.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
